// File: rtl/uart_bus_master.sv
// uart_bus_master: UART 8N1 command bridge issuing single peripheral bus reads/writes.
// Define UART_BRIDGE_CHECKSUM_EN for a trailing XOR checksum byte per frame (NAK 0x15 on mismatch).
module uart_bus_master #(
    parameter int unsigned BAUD_DIV = 325,
    parameter int unsigned TIMEOUT  = 48
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        err
);
    localparam int unsigned DIV_W = $clog2(BAUD_DIV + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {
        P_IDLE, P_ADDR, P_DATA,
`ifdef UART_BRIDGE_CHECKSUM_EN
        P_CHK,
`endif
        P_ACCESS, P_RESP
    } p_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             div_phase, tick;
    rx_state_t        rx_state;
    logic             rx_meta, rx_s, rx_prev, rx_valid, rx_ferr;
    logic [3:0]       rx_ticks;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_data;
    tx_state_t        tx_state;
    logic [31:0]      tx_shift, tx_word;
    logic [7:0]       tx_cur;
    logic [3:0]       tx_ticks;
    logic [2:0]       tx_bit, tx_left, tx_nbytes;
    logic             tx_go, tx_done;
    p_state_t         p_state;
    logic             is_write, timed_out;
    logic [1:0]       byte_cnt;
    logic [31:0]      addr_sr, data_sr;
    logic [TO_W-1:0]  to_cnt;
`ifdef UART_BRIDGE_CHECKSUM_EN
    logic [7:0]       chk_acc;
`endif

    // x16 tick: one pulse per full period of the divided clock (2*BAUD_DIV cycles)
    always_ff @(posedge sysclk) begin
        if (reset) begin
            div_cnt   <= '0;
            div_phase <= 1'b0;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (div_cnt == DIV_W'(BAUD_DIV - 1)) begin
                div_cnt   <= '0;
                div_phase <= ~div_phase;
                tick      <= div_phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_ticks <= '0;
            rx_bit   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s) begin
                    rx_state <= RX_START;
                    rx_ticks <= '0;
                end
                RX_START: if (tick) begin
                    if (rx_ticks == 4'd7) begin
                        rx_ticks <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_ticks <= rx_ticks + 1'b1;
                    end
                end
                RX_DATA: if (tick) begin
                    rx_ticks <= rx_ticks + 1'b1;
                    if (rx_ticks == 4'd15) begin
                        rx_data <= {rx_s, rx_data[7:1]};
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: if (tick) begin
                    rx_ticks <= rx_ticks + 1'b1;
                    if (rx_ticks == 4'd15) begin
                        rx_state <= RX_IDLE;
                        rx_valid <= rx_s;
                        rx_ferr  <= !rx_s;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Bytes are queued MSB first in tx_shift; tx_cur shifts the active byte out LSB first
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_shift <= '0;
            tx_cur   <= '0;
            tx_ticks <= '0;
            tx_bit   <= '0;
            tx_left  <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: if (tx_go) begin
                    tx_cur   <= tx_word[31:24];
                    tx_shift <= {tx_word[23:0], 8'h00};
                    tx_left  <= tx_nbytes;
                    tx_ticks <= '0;
                    uart_tx  <= 1'b0;
                    tx_state <= TX_START;
                end
                TX_START: if (tick) begin
                    tx_ticks <= tx_ticks + 1'b1;
                    if (tx_ticks == 4'd15) begin
                        uart_tx  <= tx_cur[0];
                        tx_cur   <= {1'b0, tx_cur[7:1]};
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: if (tick) begin
                    tx_ticks <= tx_ticks + 1'b1;
                    if (tx_ticks == 4'd15) begin
                        tx_bit <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            uart_tx <= tx_cur[0];
                            tx_cur  <= {1'b0, tx_cur[7:1]};
                        end
                    end
                end
                TX_STOP: if (tick) begin
                    tx_ticks <= tx_ticks + 1'b1;
                    if (tx_ticks == 4'd15) begin
                        if (tx_left == 3'd1) begin
                            tx_done  <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_left  <= tx_left - 1'b1;
                            tx_cur   <= tx_shift[31:24];
                            tx_shift <= {tx_shift[23:0], 8'h00};
                            uart_tx  <= 1'b0;
                            tx_state <= TX_START;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Timeout counts line-idle ticks only; a byte in flight or completing reloads it
    always_comb begin
        timed_out = tick && (to_cnt == TO_W'(TIMEOUT - 1)) && !rx_valid && (rx_state == RX_IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            p_state   <= P_IDLE;
            busy      <= 1'b0;
            err       <= 1'b0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            to_cnt    <= '0;
            tx_go     <= 1'b0;
            tx_word   <= '0;
            tx_nbytes <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
            chk_acc   <= '0;
`endif
        end else begin
            err   <= rx_ferr;
            rd    <= 1'b0;
            wr    <= 1'b0;
            tx_go <= 1'b0;
            if (rx_valid || rx_state != RX_IDLE) to_cnt <= '0;
            else if (tick) to_cnt <= to_cnt + 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
            if (rx_valid) chk_acc <= chk_acc ^ rx_data;
`endif
            case (p_state)
                P_IDLE: if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        busy     <= 1'b1;
                        is_write <= (rx_data == CMD_W);
                        byte_cnt <= '0;
                        p_state  <= P_ADDR;
`ifdef UART_BRIDGE_CHECKSUM_EN
                        chk_acc  <= rx_data;
`endif
                    end else begin
                        err <= 1'b1;
                    end
                end
                P_ADDR, P_DATA: begin
                    if (timed_out) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        p_state <= P_IDLE;
                    end else if (rx_valid) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (p_state == P_ADDR) addr_sr <= {addr_sr[23:0], rx_data};
                        else                   data_sr <= {data_sr[23:0], rx_data};
                        if (byte_cnt == 2'd3) begin
                            if (p_state == P_ADDR && is_write) begin
                                p_state <= P_DATA;
                            end else begin
`ifdef UART_BRIDGE_CHECKSUM_EN
                                p_state <= P_CHK;
`else
                                if (is_write) begin
                                    addr  <= addr_sr;
                                    wdata <= {data_sr[23:0], rx_data};
                                    wr    <= 1'b1;
                                end else begin
                                    addr <= {addr_sr[23:0], rx_data};
                                    rd   <= 1'b1;
                                end
                                p_state <= P_ACCESS;
`endif
                            end
                        end
                    end
                end
`ifdef UART_BRIDGE_CHECKSUM_EN
                P_CHK: begin
                    if (timed_out) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        p_state <= P_IDLE;
                    end else if (rx_valid) begin
                        if (rx_data == chk_acc) begin
                            addr <= addr_sr;
                            if (is_write) begin
                                wdata <= data_sr;
                                wr    <= 1'b1;
                            end else begin
                                rd <= 1'b1;
                            end
                            p_state <= P_ACCESS;
                        end else begin
                            err       <= 1'b1;
                            tx_word   <= {8'h15, 24'h0};
                            tx_nbytes <= 3'd1;
                            tx_go     <= 1'b1;
                            p_state   <= P_RESP;
                        end
                    end
                end
`endif
                P_ACCESS: begin
                    if (rx_valid) err <= 1'b1;
                    if (is_write) begin
                        tx_word   <= {8'h06, 24'h0};
                        tx_nbytes <= 3'd1;
                    end else begin
                        tx_word   <= rdata;
                        tx_nbytes <= 3'd4;
                    end
                    tx_go   <= 1'b1;
                    p_state <= P_RESP;
                end
                P_RESP: begin
                    if (rx_valid) err <= 1'b1;
                    if (tx_done) begin
                        busy    <= 1'b0;
                        p_state <= P_IDLE;
                    end
                end
                default: p_state <= P_IDLE;
            endcase
        end
    end
endmodule
